axi_bridge: RTL and testbench
=============================

AXI_BRIDGE -- requirements
Module: axi_bridge

Interface
REQ-001 Parameter AXI_ID_W, default 4, width of arid/rid/awid/wid/bid.
REQ-002 Parameter RD_LAT_MAX, default 255, cycle limit on a read response; over-run sets rd_timeout.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 inst_sram_{req,wr,size[2],addr[32],wstrb[4],wdata[32]}  in, inst_sram_{addr_ok,data_ok,rdata[32]}  out  instruction sram-like slave port; reads only.
REQ-006 data_sram_{req,wr,size[2],addr[32],wstrb[4],wdata[32]}  in, data_sram_{addr_ok,data_ok,rdata[32]}  out  data sram-like slave port.
REQ-007 AR: arid, araddr[32], arlen[8], arsize[3], arburst[2], arlock[2], arcache[4], arprot[3], arvalid  out; arready  in.
REQ-008 R: rid, rdata[32], rresp[2], rlast, rvalid  in; rready  out.
REQ-009 AW/W: awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid, wid, wdata, wstrb, wlast, wvalid  out; awready, wready  in.
REQ-010 B: bid, bresp[2], bvalid  in; bready  out.
REQ-011 rd_timeout  out  1  sticky error flag, cleared only by reset.

Function
REQ-012 Constants: arlen/awlen=0, ar/awburst=2'b01, lock/cache/prot=0, wlast=1, ar/awsize={1'b0,size}, awid=wid=1.
REQ-013 Each port holds at most one outstanding transaction; addr_ok=req && port idle && target channel slot free, combinational, same cycle as capture.
REQ-014 Read-address FSM: AR_IDLE -> AR_SEND on capture (arvalid=1 next cycle, payload registered) -> AR_IDLE on arvalid&&arready; no same-cycle bypass of a new capture.
REQ-015 AR arbitration when both ports request reads in AR_IDLE same cycle: data wins; inst addr_ok=0 that cycle.
REQ-016 arid=0 for inst, 1 for data; rready constant 1; R beat with rid=0 -> inst_sram_data_ok=1 one cycle, rid=1 -> data_sram_data_ok=1; rdata passed combinationally.
REQ-017 Write FSM: W_IDLE -> W_SEND on data write capture (awvalid and wvalid both 1 next cycle) ; each dropped independently on its own handshake -> W_RESP when both done -> W_IDLE on bvalid (bready constant 1), data_sram_data_ok=1 that cycle.
REQ-018 Data port busy from capture until its data_ok; port idle again the cycle after data_ok (new addr_ok earliest next cycle).
REQ-019 A data-port write blocks inst reads only if BRIDGE_RD_ID_SPLIT_EN undefined (see Configuration); inst reads are otherwise unordered vs data writes.
REQ-020 rresp/bresp ignored for data; rd_timeout set if any read outstanding > RD_LAT_MAX cycles after AR handshake.
REQ-021 inst_sram write request (wr=1) never receives addr_ok.

Reset
REQ-022 On reset: all FSMs idle, arvalid/awvalid/wvalid=0, addr_ok/data_ok=0, rd_timeout=0, counters 0, rready/bready=1.
REQ-023 Reset mid-transaction discards all tracking; in-flight AXI responses after reset release are dropped (no data_ok).

Configuration
REQ-024 Macro BRIDGE_RD_ID_SPLIT_EN defined: inst and data reads outstanding concurrently, routed by rid.
REQ-025 Undefined: arid=0 always, one read outstanding globally, response routed by registered owner bit; no read captured while a write is outside W_IDLE.

Structure
REQ-026 Package axi_bridge_pkg: burst/size constants, ARID_INST/ARID_DATA/AWID values, AR and W state enums.
REQ-027 One sub-module axi_bridge_wr containing the write FSM and AW/W/B channels.

Verification
REQ-028 Inst read 0x1c000000, arready=1, rvalid rid=0 rdata=0x02c00000 three cycles later -> inst_sram_data_ok one cycle with that rdata.
REQ-029 Inst and data reads same cycle -> data addr_ok=1, inst addr_ok=0; data AR first (arid=1), inst AR after.
REQ-030 Data write addr 0x10, wstrb 4'b0011, awready 2 cycles before wready -> awvalid drops first, data_ok on bvalid only.
REQ-031 With split: rid=1 response precedes rid=0 -> data_ok then inst_ok in arrival order; without split: second read addr_ok stays 0 until first response.
REQ-032 reset asserted while awvalid=1 -> awvalid=0 immediately; later bvalid ignored, no data_ok.
REQ-033 Read with rvalid withheld 256 cycles -> rd_timeout=1, stays 1 until reset.

Source files
------------

// File: rtl/axi_bridge_pkg.sv
// rtl/axi_bridge_pkg.sv - shared AXI constants, ids and FSM state types for axi_bridge
package axi_bridge_pkg;

  localparam logic [7:0] AXI_LEN_SINGLE  = 8'd0;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;
  localparam logic [3:0] AXI_CACHE_NONE  = 4'b0000;
  localparam logic [2:0] AXI_PROT_NONE   = 3'b000;

  localparam int ARID_INST = 0;
  localparam int ARID_DATA = 1;
  localparam int AWID      = 1;

  typedef enum logic {
    AR_IDLE,
    AR_SEND
  } ar_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_SEND,
    W_RESP
  } w_state_t;

  // sram-like size (bytes = 1 << size) maps directly onto AXI size
  function automatic logic [2:0] axi_size(input logic [1:0] sram_size);
    return {1'b0, sram_size};
  endfunction

endpackage

// File: rtl/axi_bridge_wr.sv
// rtl/axi_bridge_wr.sv - data-port write engine: write FSM plus AW, W and B channels
module axi_bridge_wr #(
  parameter int AXI_ID_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [31:0]         addr,
  input  logic [1:0]          size,
  input  logic [3:0]          wstrb_in,
  input  logic [31:0]         wdata_in,
  output logic                idle,
  output logic                data_ok,
  output logic [AXI_ID_W-1:0] awid,
  output logic [31:0]         awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [AXI_ID_W-1:0] wid,
  output logic [31:0]         wdata,
  output logic [3:0]          wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [AXI_ID_W-1:0] bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);
  import axi_bridge_pkg::*;

  w_state_t    state, state_next;
  logic        aw_pend, w_pend;
  logic        aw_clear, w_clear;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  size_q;
  logic        unused_wr;

  assign idle     = (state == W_IDLE);
  assign awvalid  = (state == W_SEND) && aw_pend;
  assign wvalid   = (state == W_SEND) && w_pend;
  assign aw_clear = !aw_pend || awready;
  assign w_clear  = !w_pend || wready;
  assign data_ok  = (state == W_RESP) && bvalid;
  assign bready   = 1'b1;

  assign awid    = AXI_ID_W'(AWID);
  assign awaddr  = addr_q;
  assign awlen   = AXI_LEN_SINGLE;
  assign awsize  = axi_size(size_q);
  assign awburst = AXI_BURST_INCR;
  assign awlock  = AXI_LOCK_NORMAL;
  assign awcache = AXI_CACHE_NONE;
  assign awprot  = AXI_PROT_NONE;
  assign wid     = AXI_ID_W'(AWID);
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;

  // write response status and id carry nothing the sram-like port can report
  assign unused_wr = ^{bid, bresp};

  // write FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= W_IDLE;
    else       state <= state_next;
  end

  // write FSM next state: leave SEND once both AW and W have handshaken
  always_comb begin
    state_next = state;
    case (state)
      W_IDLE:  if (start) state_next = W_SEND;
      W_SEND:  if (aw_clear && w_clear) state_next = W_RESP;
      W_RESP:  if (bvalid) state_next = W_IDLE;
      default: state_next = W_IDLE;
    endcase
  end

  // AW and W each drop independently on their own handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
    end else if (start && idle) begin
      aw_pend <= 1'b1;
      w_pend  <= 1'b1;
    end else begin
      if (awvalid && awready) aw_pend <= 1'b0;
      if (wvalid && wready)   w_pend  <= 1'b0;
    end
  end

  // write payload captured together with the request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      size_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
    end else if (start && idle) begin
      addr_q  <= addr;
      size_q  <= size;
      wstrb_q <= wstrb_in;
      wdata_q <= wdata_in;
    end
  end

endmodule

// File: rtl/axi_bridge.sv
// rtl/axi_bridge.sv - dual sram-like to AXI bridge; BRIDGE_RD_ID_SPLIT_EN enables concurrent rid-routed reads
module axi_bridge #(
  parameter int AXI_ID_W   = 4,
  parameter int RD_LAT_MAX = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_sram_req,
  input  logic                inst_sram_wr,
  input  logic [1:0]          inst_sram_size,
  input  logic [31:0]         inst_sram_addr,
  input  logic [3:0]          inst_sram_wstrb,
  input  logic [31:0]         inst_sram_wdata,
  output logic                inst_sram_addr_ok,
  output logic                inst_sram_data_ok,
  output logic [31:0]         inst_sram_rdata,
  input  logic                data_sram_req,
  input  logic                data_sram_wr,
  input  logic [1:0]          data_sram_size,
  input  logic [31:0]         data_sram_addr,
  input  logic [3:0]          data_sram_wstrb,
  input  logic [31:0]         data_sram_wdata,
  output logic                data_sram_addr_ok,
  output logic                data_sram_data_ok,
  output logic [31:0]         data_sram_rdata,
  output logic [AXI_ID_W-1:0] arid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [AXI_ID_W-1:0] rid,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [AXI_ID_W-1:0] awid,
  output logic [31:0]         awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [AXI_ID_W-1:0] wid,
  output logic [31:0]         wdata,
  output logic [3:0]          wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [AXI_ID_W-1:0] bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic                rd_timeout
);
  import axi_bridge_pkg::*;

  localparam int CW = (RD_LAT_MAX < 1) ? 1 : $clog2(RD_LAT_MAX + 1);
  localparam logic [CW-1:0] LAT_MAX = CW'(RD_LAT_MAX);

  ar_state_t   ar_state, ar_next;
  logic        ar_id_q;
  logic [31:0] ar_addr_q;
  logic [1:0]  ar_size_q;
  logic        ar_idle, ar_hs, rd_gate;
  logic        inst_rd_take, data_rd_take, data_wr_take;
  logic        inst_rd_busy, data_rd_busy, data_busy;
  logic        inst_rd_wait, data_rd_wait;
  logic        inst_rsp, data_rsp;
  logic [CW-1:0] inst_cnt, data_cnt;
  logic        wr_idle, wr_data_ok;
  logic        unused_top;

  assign ar_idle   = (ar_state == AR_IDLE);
  assign ar_hs     = arvalid && arready;
  assign data_busy = data_rd_busy || !wr_idle;

`ifdef BRIDGE_RD_ID_SPLIT_EN
  assign rd_gate  = ar_idle;
  assign inst_rsp = rvalid && inst_rd_wait && (rid == AXI_ID_W'(ARID_INST));
  assign data_rsp = rvalid && data_rd_wait && (rid == AXI_ID_W'(ARID_DATA));
  assign arid     = ar_id_q ? AXI_ID_W'(ARID_DATA) : AXI_ID_W'(ARID_INST);
`else
  // single read in flight and none while a write is active; the wait flags name the owner
  assign rd_gate  = ar_idle && !inst_rd_busy && !data_rd_busy && wr_idle;
  assign inst_rsp = rvalid && inst_rd_wait;
  assign data_rsp = rvalid && data_rd_wait;
  assign arid     = AXI_ID_W'(ARID_INST);
`endif

  // data port wins the read address slot when both ports ask in the same cycle
  assign data_rd_take = data_sram_req && !data_sram_wr && !data_busy && rd_gate;
  assign data_wr_take = data_sram_req && data_sram_wr && !data_busy && wr_idle;
  assign inst_rd_take = inst_sram_req && !inst_sram_wr && !inst_rd_busy && rd_gate && !data_rd_take;

  assign inst_sram_addr_ok = inst_rd_take;
  assign data_sram_addr_ok = data_rd_take || data_wr_take;
  assign inst_sram_data_ok = inst_rsp;
  assign data_sram_data_ok = data_rsp || wr_data_ok;
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;

  assign arvalid = (ar_state == AR_SEND);
  assign araddr  = ar_addr_q;
  assign arlen   = AXI_LEN_SINGLE;
  assign arsize  = axi_size(ar_size_q);
  assign arburst = AXI_BURST_INCR;
  assign arlock  = AXI_LOCK_NORMAL;
  assign arcache = AXI_CACHE_NONE;
  assign arprot  = AXI_PROT_NONE;
  assign rready  = 1'b1;

  // the instruction port never writes; read status and rlast carry nothing useful here
  assign unused_top = ^{inst_sram_wstrb, inst_sram_wdata, rresp, rlast, rid};

  // read-address FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ar_state <= AR_IDLE;
    else       ar_state <= ar_next;
  end

  // read-address FSM next state: one captured request per AR handshake
  always_comb begin
    ar_next = ar_state;
    case (ar_state)
      AR_IDLE: if (inst_rd_take || data_rd_take) ar_next = AR_SEND;
      AR_SEND: if (arready) ar_next = AR_IDLE;
      default: ar_next = AR_IDLE;
    endcase
  end

  // AR payload registered at capture so arvalid never waits on a combinational request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ar_id_q   <= 1'b0;
      ar_addr_q <= '0;
      ar_size_q <= '0;
    end else if (inst_rd_take || data_rd_take) begin
      ar_id_q   <= data_rd_take;
      ar_addr_q <= data_rd_take ? data_sram_addr : inst_sram_addr;
      ar_size_q <= data_rd_take ? data_sram_size : inst_sram_size;
    end
  end

  // per-port read tracking: busy from capture to data_ok, waiting from AR handshake to response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_rd_busy <= 1'b0;
      data_rd_busy <= 1'b0;
      inst_rd_wait <= 1'b0;
      data_rd_wait <= 1'b0;
    end else begin
      if (inst_rd_take)          inst_rd_busy <= 1'b1;
      else if (inst_rsp)         inst_rd_busy <= 1'b0;
      if (data_rd_take)          data_rd_busy <= 1'b1;
      else if (data_rsp)         data_rd_busy <= 1'b0;
      if (ar_hs && !ar_id_q)     inst_rd_wait <= 1'b1;
      else if (inst_rsp)         inst_rd_wait <= 1'b0;
      if (ar_hs && ar_id_q)      data_rd_wait <= 1'b1;
      else if (data_rsp)         data_rd_wait <= 1'b0;
    end
  end

  // read latency counters saturate at the limit; timeout latches until reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_cnt   <= '0;
      data_cnt   <= '0;
      rd_timeout <= 1'b0;
    end else begin
      if (ar_hs && !ar_id_q)
        inst_cnt <= '0;
      else if (inst_rd_wait && !inst_rsp && inst_cnt != LAT_MAX)
        inst_cnt <= inst_cnt + 1'b1;
      if (ar_hs && ar_id_q)
        data_cnt <= '0;
      else if (data_rd_wait && !data_rsp && data_cnt != LAT_MAX)
        data_cnt <= data_cnt + 1'b1;
      if ((inst_rd_wait && !inst_rsp && inst_cnt == LAT_MAX) ||
          (data_rd_wait && !data_rsp && data_cnt == LAT_MAX))
        rd_timeout <= 1'b1;
    end
  end

  axi_bridge_wr #(.AXI_ID_W(AXI_ID_W)) u_wr (
    .clk      (clk),
    .reset    (reset),
    .start    (data_wr_take),
    .addr     (data_sram_addr),
    .size     (data_sram_size),
    .wstrb_in (data_sram_wstrb),
    .wdata_in (data_sram_wdata),
    .idle     (wr_idle),
    .data_ok  (wr_data_ok),
    .awid     (awid),
    .awaddr   (awaddr),
    .awlen    (awlen),
    .awsize   (awsize),
    .awburst  (awburst),
    .awlock   (awlock),
    .awcache  (awcache),
    .awprot   (awprot),
    .awvalid  (awvalid),
    .awready  (awready),
    .wid      (wid),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wlast    (wlast),
    .wvalid   (wvalid),
    .wready   (wready),
    .bid      (bid),
    .bresp    (bresp),
    .bvalid   (bvalid),
    .bready   (bready)
  );

endmodule

// File: tb/tb_axi_bridge.sv
// tb/tb_axi_bridge.sv - directed self-checking bench for axi_bridge
module tb_axi_bridge;

`ifdef BRIDGE_RD_ID_SPLIT_EN
  localparam logic [3:0] EXP_DATA_ARID = 4'd1;
  localparam logic       EXP_INST_OK_DURING_WR = 1'b1;
`else
  localparam logic [3:0] EXP_DATA_ARID = 4'd0;
  localparam logic       EXP_INST_OK_DURING_WR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic [3:0]  inst_sram_wstrb;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic [3:0]  data_sram_wstrb;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, rid, awid, wid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, rresp, awburst, awlock, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        rd_timeout;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  axi_bridge #(.AXI_ID_W(4), .RD_LAT_MAX(255)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_addr(data_sram_addr), .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .rd_timeout(rd_timeout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock and land on the falling edge, where inputs change and outputs are sampled
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_addr = 0;
    inst_sram_wstrb = 0; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_addr = 0;
    data_sram_wstrb = 0; data_sram_wdata = 0;
    arready = 1; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 4'd1; bresp = 0; bvalid = 0;

    // reset state
    step(); step();
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 1);
    chk("rst_bready", bready, 1);
    chk("rst_timeout", rd_timeout, 0);
    chk("rst_inst_dok", inst_sram_data_ok, 0);
    chk("rst_data_dok", data_sram_data_ok, 0);
    reset = 1'b0;
    step();

    // single instruction read, response three cycles after the AR handshake
    inst_sram_req = 1; inst_sram_addr = 32'h1c00_0000; inst_sram_size = 2'd2;
    #1 chk("i_rd_addr_ok", inst_sram_addr_ok, 1);
    step();
    inst_sram_req = 0;
    #1 chk("i_rd_arvalid", arvalid, 1);
    chk("i_rd_araddr", araddr, 32'h1c00_0000);
    chk("i_rd_arid", arid, 0);
    chk("i_rd_arsize", arsize, 3'b010);
    chk("i_rd_arlen", arlen, 0);
    chk("i_rd_arburst", arburst, 2'b01);
    step();
    chk("i_rd_ar_drop", arvalid, 0);
    inst_sram_req = 1;
    #1 chk("i_rd_busy_no_ok", inst_sram_addr_ok, 0);
    inst_sram_req = 0;
    step(); step();
    rvalid = 1; rid = 0; rdata = 32'h02c0_0000;
    #1 chk("i_rd_data_ok", inst_sram_data_ok, 1);
    chk("i_rd_rdata", inst_sram_rdata, 32'h02c0_0000);
    chk("i_rd_no_data_dok", data_sram_data_ok, 0);
    step();
    rvalid = 0;
    #1 chk("i_rd_dok_one_cycle", inst_sram_data_ok, 0);
    inst_sram_req = 1;
    #1 chk("i_rd_idle_again", inst_sram_addr_ok, 1);
    inst_sram_req = 0;

    // instruction-port write is never accepted
    inst_sram_req = 1; inst_sram_wr = 1;
    #1 chk("i_wr_refused", inst_sram_addr_ok, 0);
    inst_sram_req = 0; inst_sram_wr = 0;
    step();

    // simultaneous reads: data wins the AR slot
    inst_sram_req = 1; inst_sram_addr = 32'h0000_0100;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h0000_0200; data_sram_size = 2'd2;
    #1 chk("arb_data_ok", data_sram_addr_ok, 1);
    chk("arb_inst_blocked", inst_sram_addr_ok, 0);
    step();
    data_sram_req = 0;
    #1 chk("arb_d_arvalid", arvalid, 1);
    chk("arb_d_araddr", araddr, 32'h0000_0200);
    chk("arb_d_arid", arid, EXP_DATA_ARID);
    chk("arb_inst_ar_busy", inst_sram_addr_ok, 0);
    step();
`ifdef BRIDGE_RD_ID_SPLIT_EN
    chk("split_inst_ok", inst_sram_addr_ok, 1);
    step();
    inst_sram_req = 0;
    #1 chk("arb_i_arid", arid, 0);
    chk("arb_i_araddr", araddr, 32'h0000_0100);
    step();
    rvalid = 1; rid = 1; rdata = 32'haaaa_5555;
    #1 chk("split_data_first", data_sram_data_ok, 1);
    chk("split_data_rdata", data_sram_rdata, 32'haaaa_5555);
    chk("split_no_inst_yet", inst_sram_data_ok, 0);
    step();
    rid = 0; rdata = 32'h1234_5678;
    #1 chk("split_inst_second", inst_sram_data_ok, 1);
    chk("split_no_data", data_sram_data_ok, 0);
    step();
    rvalid = 0;
`else
    rvalid = 1; rid = 1; rdata = 32'haaaa_5555;
    #1 chk("nosplit_inst_wait", inst_sram_addr_ok, 0);
    chk("nosplit_data_dok", data_sram_data_ok, 1);
    chk("nosplit_data_rdata", data_sram_rdata, 32'haaaa_5555);
    chk("nosplit_inst_no_dok", inst_sram_data_ok, 0);
    step();
    rvalid = 0;
    #1 chk("nosplit_inst_ok", inst_sram_addr_ok, 1);
    step();
    inst_sram_req = 0;
    #1 chk("arb_i_arid", arid, 0);
    chk("arb_i_araddr", araddr, 32'h0000_0100);
    step();
    rvalid = 1; rid = 0; rdata = 32'h1234_5678;
    #1 chk("nosplit_inst_dok", inst_sram_data_ok, 1);
    chk("nosplit_no_data_dok", data_sram_data_ok, 0);
    step();
    rvalid = 0;
`endif
    step();

    // data write, AW accepted two cycles before W
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h10; data_sram_size = 2'd1;
    data_sram_wstrb = 4'b0011; data_sram_wdata = 32'hdead_beef;
    #1 chk("wr_addr_ok", data_sram_addr_ok, 1);
    step();
    data_sram_req = 0; data_sram_wr = 0;
    #1 chk("wr_awvalid", awvalid, 1);
    chk("wr_wvalid", wvalid, 1);
    chk("wr_awaddr", awaddr, 32'h10);
    chk("wr_awsize", awsize, 3'b001);
    chk("wr_wstrb", wstrb, 4'b0011);
    chk("wr_wdata", wdata, 32'hdead_beef);
    chk("wr_awid", awid, 1);
    chk("wr_wid", wid, 1);
    chk("wr_wlast", wlast, 1);
    awready = 1;
    step();
    awready = 0;
    #1 chk("wr_aw_dropped", awvalid, 0);
    chk("wr_w_held", wvalid, 1);
    inst_sram_req = 1; inst_sram_addr = 32'h0000_0300;
    #1 chk("wr_inst_rd_gate", inst_sram_addr_ok, EXP_INST_OK_DURING_WR);
    inst_sram_req = 0;
    step();
    wready = 1;
    #1 chk("wr_no_dok_w", data_sram_data_ok, 0);
    step();
    wready = 0;
    #1 chk("wr_w_dropped", wvalid, 0);
    chk("wr_no_dok_resp", data_sram_data_ok, 0);
    data_sram_req = 1;
    #1 chk("wr_port_busy", data_sram_addr_ok, 0);
    data_sram_req = 0;
    step();
    bvalid = 1;
    #1 chk("wr_dok_on_b", data_sram_data_ok, 1);
    step();
    bvalid = 0;
    #1 chk("wr_dok_one_cycle", data_sram_data_ok, 0);
    data_sram_req = 1;
    #1 chk("wr_port_idle", data_sram_addr_ok, 1);
    data_sram_req = 0;
    step();

    // reset in the middle of a write
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h20; data_sram_size = 2'd2;
    step();
    data_sram_req = 0; data_sram_wr = 0;
    #1 chk("rstw_awvalid_pre", awvalid, 1);
    reset = 1;
    #1 chk("rstw_awvalid_now", awvalid, 0);
    chk("rstw_wvalid_now", wvalid, 0);
    step();
    reset = 0;
    bvalid = 1;
    #1 chk("rstw_b_ignored", data_sram_data_ok, 0);
    step();
    bvalid = 0;
    step();

    // read response withheld past the latency limit
    inst_sram_req = 1; inst_sram_addr = 32'h40;
    step();
    inst_sram_req = 0;
    #1 chk("to_arvalid", arvalid, 1);
    @(posedge clk);
    repeat (250) @(posedge clk);
    @(negedge clk);
    chk("to_not_yet", rd_timeout, 0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("to_set", rd_timeout, 1);
    rvalid = 1; rid = 0; rdata = 32'h5a5a_5a5a;
    #1 chk("to_late_rsp", inst_sram_data_ok, 1);
    step();
    rvalid = 0;
    step();
    chk("to_sticky", rd_timeout, 1);
    reset = 1;
    #1 chk("to_cleared", rd_timeout, 0);
    step();
    reset = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
